sobel_3x3: RTL



---
 rtl/sobel_3x3.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_3x3.sv
// -----------------------------------------------------------------------------
// sobel_3x3
//
// Purpose:
//   Builds a 3x3 pixel window from the 3-row column stream produced by the line
//   buffer. For every interior window centre it outputs the Sobel gradient
//   magnitude |Gx| + |Gy|, saturated to 7 bits. The pixel leaves together with
//   the hcount/vcount of the window centre. Border pixels are never emitted.
//
// Pipeline (edges counted from the edge that samples the completing column):
//   edge 0 : window shift-in, fill counter and centre coordinates
//   edge 1 : window-complete valid and the four weighted column/row sums
//   edge 2 : signed Gx / Gy
//   edge 3 : magnitude, saturation or binarize, output registers
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-low reset
//   line_buffer_in  column pixels: [2]=top row, [1]=centre row, [0]=bottom row
//   hcount_in       column index of line_buffer_in
//   vcount_in       centre-row index of line_buffer_in
//   data_valid_in   column valid
//   threshold_in    binarize threshold (used only with SOBEL_BINARIZE_EN)
//   pixel_out       gradient magnitude (or binarized edge)
//   hcount_out      centre column of pixel_out
//   vcount_out      centre row of pixel_out
//   data_valid_out  pixel_out valid
//
// Build option:
//   SOBEL_BINARIZE_EN - when defined, pixel_out = (mag > threshold_in) ? 127 : 0.
//                       When undefined, threshold_in is ignored.
// -----------------------------------------------------------------------------
module sobel_3x3 #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [2:0][6:0] line_buffer_in,
  input  logic [10:0]     hcount_in,
  input  logic [9:0]      vcount_in,
  input  logic            data_valid_in,
  input  logic [6:0]      threshold_in,
  output logic [6:0]      pixel_out,
  output logic [10:0]     hcount_out,
  output logic [9:0]      vcount_out,
  output logic            data_valid_out
);

  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST = 10'd1;
  localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 2);
  localparam logic [1:0]  FILL_MAX = 2'd2;

  // ---------------------------------------------------------------------------
  // Stage 1: window registers
  // ---------------------------------------------------------------------------
  logic [2:0][6:0] col_l_q, col_l_d;
  logic [2:0][6:0] col_c_q, col_c_d;
  logic [2:0][6:0] col_r_q, col_r_d;
  logic [1:0]      fill_q, fill_d;
  // Set by the first hcount_in==0 column after reset. Without it a stream that
  // resumes mid-line after reset would fill the window from an arbitrary
  // column and emit before the next line start.
  logic            sync_q, sync_d;
  // A new column was loaded on the last edge; this is the head of the valid
  // chain, so idle cycles inject a 0 here even though the window holds.
  logic            load_q, load_d;
  logic [10:0]     hc_c_q, hc_c_d;
  logic [9:0]      vc_c_q, vc_c_d;
  logic [10:0]     last_hc_q, last_hc_d;

  // ---------------------------------------------------------------------------
  // Window-complete valid and weighted sums
  // ---------------------------------------------------------------------------
  logic            v1_q, v1_d;
  logic [10:0]     hc1_q, hc1_d;
  logic [9:0]      vc1_q, vc1_d;
  logic [8:0]      sum_r_q, sum_r_d;   // TR + 2*MR + BR
  logic [8:0]      sum_l_q, sum_l_d;   // TL + 2*ML + BL
  logic [8:0]      sum_b_q, sum_b_d;   // BL + 2*BC + BR
  logic [8:0]      sum_t_q, sum_t_d;   // TL + 2*TC + TR

  // ---------------------------------------------------------------------------
  // Stage 2: signed gradients
  // ---------------------------------------------------------------------------
  logic               v2_q, v2_d;
  logic [10:0]        hc2_q, hc2_d;
  logic [9:0]         vc2_q, vc2_d;
  logic signed [9:0]  gx_q, gx_d;
  logic signed [9:0]  gy_q, gy_d;

  // ---------------------------------------------------------------------------
  // Stage 3: output registers
  // ---------------------------------------------------------------------------
  logic [6:0]  pix_q, pix_d;
  logic [10:0] hco_q, hco_d;
  logic [9:0]  vco_q, vco_d;
  logic        dvo_q, dvo_d;

  // Combinational helpers
  logic [9:0]  abs_gx;
  logic [9:0]  abs_gy;
  logic [10:0] mag;
  logic        window_ok;

  // 1-2-1 weighted sum of three 7-bit pixels; max 4*127 = 508 fits in 9 bits.
  function automatic logic [8:0] wsum(input logic [6:0] a,
                                      input logic [6:0] m,
                                      input logic [6:0] b);
    return {2'b00, a} + {1'b0, m, 1'b0} + {2'b00, b};
  endfunction

`ifndef SOBEL_BINARIZE_EN
  // Threshold only matters for the binarized build.
  logic unused_threshold;
  assign unused_threshold = ^threshold_in;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Defaults: hold everything
    col_l_d   = col_l_q;
    col_c_d   = col_c_q;
    col_r_d   = col_r_q;
    fill_d    = fill_q;
    sync_d    = sync_q;
    load_d    = data_valid_in;
    hc_c_d    = hc_c_q;
    vc_c_d    = vc_c_q;
    last_hc_d = last_hc_q;

    // ---- stage 1: window shift on valid columns only -------------------
    if (data_valid_in) begin
      col_l_d   = col_c_q;
      col_c_d   = col_r_q;
      col_r_d   = line_buffer_in;
      hc_c_d    = hcount_in - 11'd1;
      vc_c_d    = vcount_in;
      last_hc_d = hcount_in;
      if (hcount_in == 11'd0) begin
        // Line start: the two older columns belong to the previous line and
        // must age out before the window counts as complete again.
        fill_d = 2'd0;
        sync_d = 1'b1;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 2'd1;
      end
    end

    // ---- window-complete judged from the window loaded on the last edge --
    window_ok = sync_q
             && (fill_q == FILL_MAX)
             && (vc_c_q >= V_FIRST)
             && (vc_c_q <= V_LAST)
             && (last_hc_q <= H_LAST);

    v1_d    = load_q && window_ok;
    hc1_d   = hc_c_q;
    vc1_d   = vc_c_q;
    sum_r_d = wsum(col_r_q[2], col_r_q[1], col_r_q[0]);
    sum_l_d = wsum(col_l_q[2], col_l_q[1], col_l_q[0]);
    sum_b_d = wsum(col_l_q[0], col_c_q[0], col_r_q[0]);
    sum_t_d = wsum(col_l_q[2], col_c_q[2], col_r_q[2]);

    // ---- stage 2: gradients (each in -508..508) --------------------------
    v2_d  = v1_q;
    hc2_d = hc1_q;
    vc2_d = vc1_q;
    gx_d  = $signed({1'b0, sum_r_q}) - $signed({1'b0, sum_l_q});
    gy_d  = $signed({1'b0, sum_b_q}) - $signed({1'b0, sum_t_q});

    // ---- stage 3: magnitude ----------------------------------------------
    abs_gx = gx_q[9] ? (~gx_q + 10'd1) : gx_q;
    abs_gy = gy_q[9] ? (~gy_q + 10'd1) : gy_q;
    mag    = {1'b0, abs_gx} + {1'b0, abs_gy};

    dvo_d = v2_q;
    pix_d = pix_q;
    hco_d = hco_q;
    vco_d = vco_q;
    // Output data and coordinates only move with a valid result, so they
    // hold their last value across gaps.
    if (v2_q) begin
      hco_d = hc2_q;
      vco_d = vc2_q;
`ifdef SOBEL_BINARIZE_EN
      pix_d = (mag > {4'b0000, threshold_in}) ? 7'd127 : 7'd0;
`else
      pix_d = (mag > 11'd127) ? 7'd127 : mag[6:0];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      col_l_q   <= '0;
      col_c_q   <= '0;
      col_r_q   <= '0;
      fill_q    <= 2'd0;
      sync_q    <= 1'b0;
      load_q    <= 1'b0;
      hc_c_q    <= 11'd0;
      vc_c_q    <= 10'd0;
      last_hc_q <= 11'd0;
      v1_q      <= 1'b0;
      hc1_q     <= 11'd0;
      vc1_q     <= 10'd0;
      sum_r_q   <= 9'd0;
      sum_l_q   <= 9'd0;
      sum_b_q   <= 9'd0;
      sum_t_q   <= 9'd0;
      v2_q      <= 1'b0;
      hc2_q     <= 11'd0;
      vc2_q     <= 10'd0;
      gx_q      <= 10'sd0;
      gy_q      <= 10'sd0;
      pix_q     <= 7'd0;
      hco_q     <= 11'd0;
      vco_q     <= 10'd0;
      dvo_q     <= 1'b0;
    end else begin
      col_l_q   <= col_l_d;
      col_c_q   <= col_c_d;
      col_r_q   <= col_r_d;
      fill_q    <= fill_d;
      sync_q    <= sync_d;
      load_q    <= load_d;
      hc_c_q    <= hc_c_d;
      vc_c_q    <= vc_c_d;
      last_hc_q <= last_hc_d;
      v1_q      <= v1_d;
      hc1_q     <= hc1_d;
      vc1_q     <= vc1_d;
      sum_r_q   <= sum_r_d;
      sum_l_q   <= sum_l_d;
      sum_b_q   <= sum_b_d;
      sum_t_q   <= sum_t_d;
      v2_q      <= v2_d;
      hc2_q     <= hc2_d;
      vc2_q     <= vc2_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      pix_q     <= pix_d;
      hco_q     <= hco_d;
      vco_q     <= vco_d;
      dvo_q     <= dvo_d;
    end
  end

  assign pixel_out      = pix_q;
  assign hcount_out     = hco_q;
  assign vcount_out     = vco_q;
  assign data_valid_out = dvo_q;

endmodule
